// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks: game state encoding,
// score width and default score/level constants.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam int SCORE_WIDTH    = 7;
  localparam int SCORE_MAX_DEF  = 99;
  localparam int LEVEL_STEP_DEF = 10;

  typedef logic [SCORE_WIDTH-1:0] score_t;
  typedef logic [1:0]             level_t;

  localparam level_t LEVEL_MAX = 2'd3;

endpackage

// File: rtl/score_keeper_if.sv
// Game-event and score-display bundle between the game logic (master)
// and the score keeper (slave).
interface score_keeper_if;
  import snake_pkg::*;

  logic   game_start;
  logic   apple_eaten;
  logic   game_over;
  score_t score;
  logic   score_clr;
  level_t speed_level;
  logic   playing;
  score_t high_score;
  logic   new_record;

  modport master (
    output game_start, apple_eaten, game_over,
    input  score, score_clr, speed_level, playing, high_score, new_record
  );

  modport slave (
    input  game_start, apple_eaten, game_over,
    output score, score_clr, speed_level, playing, high_score, new_record
  );

endinterface

// File: rtl/score_keeper_rise_detect.sv
// Single-bit rising-edge detector: pulse while the input is high and the
// registered previous value is low.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = clr_i ? 1'b0 : d_i;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/score_keeper.sv
// Snake score keeper: IDLE/PLAY/OVER FSM, saturating score, speed level.
// Define SCORE_KEEPER_HIGH_SCORE_EN to keep a high score and record flag.
module score_keeper
  import snake_pkg::*;
#(
  parameter int SCORE_MAX  = SCORE_MAX_DEF,
  parameter int LEVEL_STEP = LEVEL_STEP_DEF
) (
  input  logic          clock_25,
  input  logic          reset,
  input  logic          sync_reset,
  score_keeper_if.slave bus
);

  // Clamp so the score always fits the two-digit display.
  localparam int SAT    = (SCORE_MAX > 99) ? 99 : SCORE_MAX;
  localparam int STEP_N = (LEVEL_STEP < 1) ? 1 : LEVEL_STEP;
  localparam int STEP_W = (STEP_N > 1) ? $clog2(STEP_N) : 1;

  typedef logic [STEP_W-1:0] step_t;

  localparam score_t SCORE_SAT = score_t'(SAT);
  localparam step_t  STEP_LAST = step_t'(STEP_N - 1);

  state_e state_q, state_d;
  score_t score_q, score_d;
  step_t  step_q,  step_d;
  level_t level_q, level_d;
  logic   clr_q,   clr_d;
  logic   apple_rise;

  rise_detect u_apple_rise (
    .clk    (clock_25),
    .rst_n  (reset),
    .clr_i  (sync_reset),
    .d_i    (bus.apple_eaten),
    .rise_o (apple_rise)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    score_d = score_q;
    step_d  = step_q;
    level_d = level_q;
    clr_d   = 1'b0;

    unique case (state_q)
      IDLE, OVER: begin
        if (bus.game_start) begin
          state_d = PLAY;
          score_d = '0;
          step_d  = '0;
          level_d = '0;
          clr_d   = 1'b1;
        end
      end
      PLAY: begin
        if (apple_rise && (score_q < SCORE_SAT)) begin
          score_d = score_q + 1'b1;
          if (step_q == STEP_LAST) begin
            step_d = '0;
            if (level_q != LEVEL_MAX) level_d = level_q + 2'd1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        if (bus.game_over) state_d = OVER;
      end
      default: state_d = IDLE;
    endcase

    // Synchronous clear has the same effect as the async reset.
    if (sync_reset) begin
      state_d = IDLE;
      score_d = '0;
      step_d  = '0;
      level_d = '0;
      clr_d   = 1'b0;
    end
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      score_q <= '0;
      step_q  <= '0;
      level_q <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      step_q  <= step_d;
      level_q <= level_d;
      clr_q   <= clr_d;
    end
  end

  assign bus.score       = score_q;
  assign bus.score_clr   = clr_q;
  assign bus.speed_level = level_q;
  assign bus.playing     = (state_q == PLAY);

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  score_t high_q, high_d;
  logic   rec_q,  rec_d;

  // Record check uses score_d so an apple on the final cycle is included.
  always_comb begin
    high_d = high_q;
    rec_d  = rec_q;
    if ((state_q == PLAY) && (state_d == OVER)) begin
      rec_d = (score_d > high_q);
      if (score_d > high_q) high_d = score_d;
    end else if ((state_q == OVER) && (state_d != OVER)) begin
      rec_d = 1'b0;
    end
    if (sync_reset) begin
      high_d = '0;
      rec_d  = 1'b0;
    end
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      high_q <= '0;
      rec_q  <= 1'b0;
    end else begin
      high_q <= high_d;
      rec_q  <= rec_d;
    end
  end

  assign bus.high_score = high_q;
  assign bus.new_record = rec_q;
`else
  assign bus.high_score = '0;
  assign bus.new_record = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: expected output views are pushed when
// stimulus is applied and popped/compared at the following falling edge.
module tb_score_keeper;
  import snake_pkg::*;

  localparam int SMAX  = 99;
  localparam int LSTEP = 10;
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  typedef struct packed {
    score_t score;
    level_t level;
    logic   clr;
    logic   play;
    score_t hs;
    logic   rec;
  } view_t;

  logic clock_25 = 1'b0;
  logic reset;
  logic sync_reset;

  score_keeper_if bus ();

  score_keeper #(.SCORE_MAX(SMAX), .LEVEL_STEP(LSTEP)) dut (
    .clock_25   (clock_25),
    .reset      (reset),
    .sync_reset (sync_reset),
    .bus        (bus)
  );

  always #20 clock_25 = ~clock_25;

  view_t obs;
  assign obs = {bus.score, bus.speed_level, bus.score_clr, bus.playing,
                bus.high_score, bus.new_record};

  view_t exp_q[$];
  view_t got, want;
  int    n_vec = 0;
  int    n_err = 0;

  // Reference model of the game, expressed as apples eaten this game.
  int     m_apples = 0;
  logic   m_play   = 1'b0;
  score_t m_best   = '0;
  logic   m_rec    = 1'b0;

  function automatic view_t model_view(input logic clr);
    int c, l;
    c = (m_apples > SMAX) ? SMAX : m_apples;
    l = c / LSTEP;
    if (l > 3) l = 3;
    model_view = '{score: score_t'(c), level: level_t'(l), clr: clr,
                   play: m_play, hs: m_best, rec: m_rec};
  endfunction

  task automatic step();
    @(posedge clock_25);
    @(negedge clock_25);
  endtask

  task automatic model_end_game();
    int c;
    c = (m_apples > SMAX) ? SMAX : m_apples;
    m_rec = HS_EN && (score_t'(c) > m_best);
    if (m_rec) m_best = score_t'(c);
    m_play = 1'b0;
  endtask

  task automatic model_start_game();
    m_apples = 0;
    m_play   = 1'b1;
    m_rec    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sync_reset = 1'b0;
    bus.game_start = 1'b0;
    bus.apple_eaten = 1'b0;
    bus.game_over = 1'b0;
    repeat (2) step();
    exp_q.push_back(model_view(1'b0));
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL reset_state: got %p want %p", got, want);
    end
    reset = 1'b1;
    exp_q.push_back(model_view(1'b0));
    step();
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL reset_release: got %p want %p", got, want);
    end
  endtask

  task automatic test_basic();
    bus.game_start = 1'b1;
    model_start_game();
    exp_q.push_back(model_view(1'b1));
    step();
    bus.game_start = 1'b0;
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL basic_start: got %p want %p", got, want);
    end
    exp_q.push_back(model_view(1'b0));
    step();
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL basic_clr_once: got %p want %p", got, want);
    end
    for (int k = 1; k <= 3; k++) begin
      bus.apple_eaten = 1'b1;
      m_apples++;
      for (int h = 0; h < 4; h++) begin
        exp_q.push_back(model_view(1'b0));
        step();
        got = obs; want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin
          n_err++; $display("FAIL basic_apple%0d_hold%0d: got %p want %p", k, h, got, want);
        end
      end
      bus.apple_eaten = 1'b0;
      exp_q.push_back(model_view(1'b0));
      step();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL basic_apple%0d_low: got %p want %p", k, got, want);
      end
    end
  endtask

  task automatic test_ignore_start();
    bus.game_start = 1'b1;
    for (int h = 0; h < 2; h++) begin
      exp_q.push_back(model_view(1'b0));
      step();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL start_in_play%0d: got %p want %p", h, got, want);
      end
    end
    bus.game_start = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      bus.apple_eaten = 1'b1;
      m_apples++;
      exp_q.push_back(model_view(1'b0));
      step();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL b2b_edge%0d: got %p want %p", k, got, want);
      end
      bus.apple_eaten = 1'b0;
      exp_q.push_back(model_view(1'b0));
      step();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL b2b_gap%0d: got %p want %p", k, got, want);
      end
    end
  endtask

  task automatic test_simul_over();
    bus.apple_eaten = 1'b1;
    bus.game_over = 1'b1;
    m_apples++;
    model_end_game();
    exp_q.push_back(model_view(1'b0));
    step();
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL simul_apple_over: got %p want %p", got, want);
    end
    bus.game_over = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.apple_eaten = 1'b0;
      exp_q.push_back(model_view(1'b0));
      step();
      bus.apple_eaten = 1'b1;
      exp_q.push_back(model_view(1'b0));
      step();
      got = obs; want = exp_q.pop_front(); n_vec++;
      want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL over_apple_ignored%0d: got %p want %p", k, got, want);
      end
    end
    bus.apple_eaten = 1'b0;
    step();
  endtask

  task automatic test_restart();
    bus.game_start = 1'b1;
    model_start_game();
    exp_q.push_back(model_view(1'b1));
    step();
    bus.game_start = 1'b0;
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL restart_clear: got %p want %p", got, want);
    end
    exp_q.push_back(model_view(1'b0));
    step();
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL restart_clr_one_cycle: got %p want %p", got, want);
    end
  endtask

  task automatic test_second_game();
    for (int k = 0; k < 5; k++) begin
      bus.apple_eaten = 1'b1;
      m_apples++;
      exp_q.push_back(model_view(1'b0));
      step();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL game2_apple%0d: got %p want %p", k, got, want);
      end
      bus.apple_eaten = 1'b0;
      step();
    end
    bus.game_over = 1'b1;
    model_end_game();
    exp_q.push_back(model_view(1'b0));
    step();
    bus.game_over = 1'b0;
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL game2_over_no_record: got %p want %p", got, want);
    end
  endtask

  task automatic test_levels();
    bus.game_start = 1'b1;
    model_start_game();
    exp_q.push_back(model_view(1'b1));
    step();
    bus.game_start = 1'b0;
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL levels_start: got %p want %p", got, want);
    end
    for (int n = 1; n <= 105; n++) begin
      bus.apple_eaten = 1'b1;
      m_apples++;
      exp_q.push_back(model_view(1'b0));
      step();
      bus.apple_eaten = 1'b0;
      step();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL levels_apple%0d: got %p want %p", n, got, want);
      end
    end
  endtask

  task automatic test_sync_reset();
    sync_reset = 1'b1;
    m_apples = 0; m_play = 1'b0; m_best = '0; m_rec = 1'b0;
    exp_q.push_back(model_view(1'b0));
    step();
    sync_reset = 1'b0;
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL sync_reset_clear: got %p want %p", got, want);
    end
    bus.apple_eaten = 1'b1;
    exp_q.push_back(model_view(1'b0));
    step();
    bus.apple_eaten = 1'b0;
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL idle_apple_ignored: got %p want %p", got, want);
    end
  endtask

  task automatic test_async_reset();
    bus.game_start = 1'b1;
    model_start_game();
    step();
    bus.game_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.apple_eaten = 1'b1;
      m_apples++;
      step();
      bus.apple_eaten = 1'b0;
      step();
    end
    exp_q.push_back(model_view(1'b0));
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL async_pre_score12: got %p want %p", got, want);
    end
    bus.apple_eaten = 1'b1;
    #5 reset = 1'b0;
    m_apples = 0; m_play = 1'b0; m_best = '0; m_rec = 1'b0;
    #1;
    exp_q.push_back(model_view(1'b0));
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL async_reset_immediate: got %p want %p", got, want);
    end
    @(negedge clock_25);
    step();
    reset = 1'b1;
    step();
    bus.game_start = 1'b1;
    model_start_game();
    exp_q.push_back(model_view(1'b1));
    step();
    bus.game_start = 1'b0;
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL async_restart: got %p want %p", got, want);
    end
    for (int h = 0; h < 3; h++) begin
      exp_q.push_back(model_view(1'b0));
      step();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL held_apple_ignored%0d: got %p want %p", h, got, want);
      end
    end
    bus.apple_eaten = 1'b0;
    step();
    bus.apple_eaten = 1'b1;
    m_apples++;
    exp_q.push_back(model_view(1'b0));
    step();
    bus.apple_eaten = 1'b0;
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL fresh_apple_counted: got %p want %p", got, want);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_simul_over();
    test_restart();
    test_second_game();
    test_levels();
    test_sync_reset();
    test_async_reset();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter SCORE_MAX, default 99: saturation value of score; must be at most 99 to fit the two-digit display.
REQ-002 Parameter LEVEL_STEP, default 10: apples per speed level increment.
REQ-003 clock_25  input  1  pixel/system clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 sync_reset  input  1  synchronous clear, active-high, same effect as reset.
REQ-006 game_start  input  1  start/restart request, level, sampled each cycle.
REQ-007 apple_eaten  input  1  apple consumed; may stay high several cycles; one event per rising edge.
REQ-008 game_over  input  1  collision indication, level.
REQ-009 score  output  7  current score, binary, feeds the digit display stage.
REQ-010 score_clr  output  1  one-cycle clear pulse to the display stage's sync_reset.
REQ-011 speed_level  output  2  0..3, for snake movement timing.
REQ-012 playing  output  1  high in PLAY state.
REQ-013 high_score  output  7  best score since reset (see Configuration).
REQ-014 new_record  output  1  high in OVER when the final score exceeded the previous high_score.

Function
REQ-015 FSM states IDLE, PLAY, OVER; reset state IDLE.
REQ-016 IDLE: game_start=1 -> PLAY next cycle; score stays 0.
REQ-017 PLAY: rising edge of apple_eaten (current=1, registered previous=0) -> score+1 on the next clock edge; one event gives exactly +1.
REQ-018 Score saturates at SCORE_MAX; further apples leave score unchanged and level counter frozen.
REQ-019 The level step counter increments with each counted apple; at LEVEL_STEP-1 it wraps to 0 and speed_level increments, saturating at 3.
REQ-020 PLAY: game_over=1 -> OVER next cycle; score, speed_level frozen.
REQ-021 Simultaneous apple edge and game_over in PLAY: apple counted, then OVER; record comparison uses the incremented score.
REQ-022 game_start in PLAY is ignored.
REQ-023 OVER: apple_eaten ignored; game_start=1 -> PLAY; in that cycle score, step counter, speed_level cleared to 0 and score_clr pulses high for exactly one cycle.
REQ-024 IDLE->PLAY transition also pulses score_clr once.
REQ-025 apple edge detector register is updated in every state, so an apple held high across entry to PLAY does not count.
REQ-026 Score never decreases except via clear; successive increments may occur on consecutive edges.

Reset
REQ-027 reset low or sync_reset high: state IDLE, score 0, score_clr 0, speed_level 0, playing 0, high_score 0, new_record 0, edge register 0.
REQ-028 Reset mid-game aborts immediately; no score_clr pulse is emitted by reset itself.

Configuration
REQ-029 Macro SCORE_KEEPER_HIGH_SCORE_EN defined: on PLAY->OVER, if final score > high_score then high_score updates to the final score and new_record is set until leaving OVER.
REQ-030 Macro undefined: high_score and new_record tied to 0; no high-score registers.

Structure
REQ-031 A shared snake_pkg holds the state encoding (IDLE/PLAY/OVER), SCORE_WIDTH=7, and the default SCORE_MAX and LEVEL_STEP constants.
REQ-032 Sub-module rise_detect (single-bit registered rising-edge pulse) is instantiated for apple_eaten; all else is inline.

Verification
REQ-033 Reset, game_start, 3 apple pulses each held 4 cycles -> score 0,1,2,3; each increment one cycle after the edge; score_clr pulses once at start.
REQ-034 25 apples in PLAY -> score 25, speed_level 2; 99+ apples -> score 99, speed_level 3, no wrap.
REQ-035 apple edge and game_over in the same cycle at score 7 -> score 8, state OVER, high_score 8, new_record 1 (macro on).
REQ-036 OVER with score 8, then game_start -> score 0, speed_level 0, score_clr high exactly 1 cycle, high_score stays 8.
REQ-037 Second game ends at 5 -> high_score 8, new_record 0; macro off -> high_score 0 throughout.
REQ-038 reset asserted mid-PLAY at score 12 -> all outputs 0 asynchronously, IDLE; apple held high at restart is not counted.
